// File: rtl/regfile_scanner.sv
// Sweeps an inclusive regfile address range over the debug read port and streams (addr, data) pairs out on valid/ready.
// Optional `define SCAN_ABORT_EN adds an abort input that ends a sweep early with the normal done pulse.
module regfile_scanner #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [AW-1:0] first_addr,
  input  logic [AW-1:0] last_addr,
  output logic [AW-1:0] test_addr,
  input  logic [DW-1:0] test_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done
`ifdef SCAN_ABORT_EN
  ,
  input  logic          abort
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] test_addr_reg, test_addr_next;
  logic [AW-1:0] last_reg, last_next;
  logic [AW-1:0] out_addr_reg, out_addr_next;
  logic [DW-1:0] out_data_reg, out_data_next;
  logic          out_valid_reg, out_valid_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          abort_req;

`ifdef SCAN_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  always_comb begin
    state_next     = state_reg;
    test_addr_next = test_addr_reg;
    last_next      = last_reg;
    out_addr_next  = out_addr_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          last_next      = last_addr;
          test_addr_next = first_addr;
          state_next     = FETCH;
        end
      end
      FETCH: begin
        if (abort_req) begin
          out_valid_next = 1'b0;
          state_next     = DONE;
        end else begin
          out_addr_next  = test_addr_reg;
          out_data_next  = test_data;
          out_valid_next = 1'b1;
          state_next     = SEND;
        end
      end
      SEND: begin
        // Abort wins over a same-cycle handshake: that entry is dropped.
        if (abort_req) begin
          out_valid_next = 1'b0;
          state_next     = DONE;
        end else if (out_valid_reg && out_ready) begin
          out_valid_next = 1'b0;
          if (test_addr_reg == last_reg) begin
            state_next = DONE;
          end else begin
            test_addr_next = test_addr_reg + ADDR_ONE;
            state_next     = FETCH;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Status flags are registered copies of where the FSM is heading.
    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      test_addr_reg <= '0;
      last_reg      <= '0;
      out_addr_reg  <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      test_addr_reg <= test_addr_next;
      last_reg      <= last_next;
      out_addr_reg  <= out_addr_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  assign test_addr = test_addr_reg;
  assign out_addr  = out_addr_reg;
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_regfile_scanner.sv
// Directed self-checking bench for regfile_scanner with a behavioural regfile on the debug port.
// Define SCAN_ABORT_EN for both bench and RTL to exercise the abort path.
module tb_regfile_scanner;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic [4:0]  test_addr;
  logic [31:0] test_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        busy;
  logic        done;
`ifdef SCAN_ABORT_EN
  logic        abort;
`endif

  logic [31:0] regs [32];
  int tests;
  int fails;

  assign test_data = regs[test_addr];

  regfile_scanner #(.AW(5), .DW(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .test_addr  (test_addr),
    .test_data  (test_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done)
`ifdef SCAN_ABORT_EN
    ,
    .abort      (abort)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a sweep with out_ready held high and check every transfer plus the done/busy tail.
  task automatic sweep(input logic [4:0] f, input logic [4:0] l, input int n_exp, input string tag);
    logic [4:0] a;
    start = 1'b1; first_addr = f; last_addr = l; out_ready = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " start busy"}, 64'(busy), 64'd1);
    check({tag, " start valid"}, 64'(out_valid), 64'd0);
    check({tag, " start test_addr"}, 64'(test_addr), 64'(f));
    a = f;
    for (int k = 0; k < n_exp; k++) begin
      tick();
      check($sformatf("%s valid k=%0d", tag, k), 64'(out_valid), 64'd1);
      check($sformatf("%s addr k=%0d", tag, k), 64'(out_addr), 64'(a));
      check($sformatf("%s data k=%0d", tag, k), 64'(out_data), 64'(regs[a]));
      check($sformatf("%s no done k=%0d", tag, k), 64'(done), 64'd0);
      $display("[TB] %s transfer %0d addr=%0d data=%08h", tag, k, out_addr, out_data);
      tick();
      check($sformatf("%s drop k=%0d", tag, k), 64'(out_valid), 64'd0);
      a = a + 5'd1;
    end
    check({tag, " done pulse"}, 64'(done), 64'd1);
    check({tag, " busy in done"}, 64'(busy), 64'd1);
    tick();
    check({tag, " done cleared"}, 64'(done), 64'd0);
    check({tag, " busy cleared"}, 64'(busy), 64'd0);
    tick();
    check({tag, " idle valid"}, 64'(out_valid), 64'd0);
    check({tag, " idle done"}, 64'(done), 64'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    resetn = 1'b0;
    start = 1'b0;
    first_addr = '0;
    last_addr = '0;
    out_ready = 1'b0;
`ifdef SCAN_ABORT_EN
    abort = 1'b0;
`endif
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i);

    // Reset state
    tick();
    tick();
    check("rst test_addr", 64'(test_addr), 64'd0);
    check("rst out_addr", 64'(out_addr), 64'd0);
    check("rst out_data", 64'(out_data), 64'd0);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    resetn = 1'b1;
    tick();
    check("post-rst busy", 64'(busy), 64'd0);

    // Full sweep 0..31
    sweep(5'd0, 5'd31, 32, "full");

    // Wrap sweep 30,31,0,1
    sweep(5'd30, 5'd1, 4, "wrap");

    // Backpressure on a single-entry sweep; start pulses mid-sweep must be ignored
    regs[5] = 32'hDEAD_BEEF;
    out_ready = 1'b0;
    start = 1'b1; first_addr = 5'd5; last_addr = 5'd5;
    tick();
    start = 1'b0;
    tick();
    check("bp valid", 64'(out_valid), 64'd1);
    regs[5] = 32'h0;
    for (int k = 0; k < 7; k++) begin
      start = k[0]; first_addr = 5'd9; last_addr = 5'd20;
      tick();
      check($sformatf("bp hold valid %0d", k), 64'(out_valid), 64'd1);
      check($sformatf("bp hold addr %0d", k), 64'(out_addr), 64'd5);
      check($sformatf("bp hold data %0d", k), 64'(out_data), 64'hDEAD_BEEF);
      check($sformatf("bp hold test_addr %0d", k), 64'(test_addr), 64'd5);
      $display("[TB] bp stall %0d valid=%0b addr=%0d data=%08h", k, out_valid, out_addr, out_data);
    end
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp handshake drop", 64'(out_valid), 64'd0);
    check("bp done", 64'(done), 64'd1);
    start = 1'b1; first_addr = 5'd0; last_addr = 5'd0;
    tick();
    start = 1'b0;
    check("bp start-in-done ignored busy", 64'(busy), 64'd0);
    check("bp done one cycle", 64'(done), 64'd0);
    tick();
    check("bp idle busy", 64'(busy), 64'd0);
    check("bp idle valid", 64'(out_valid), 64'd0);
    regs[5] = 32'h1000_0005;

    // Reset mid-sweep while in SEND at address 12
    start = 1'b1; first_addr = 5'd10; last_addr = 5'd20; out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    out_ready = 1'b0;
    tick();
    check("mid SEND valid", 64'(out_valid), 64'd1);
    check("mid SEND addr", 64'(out_addr), 64'd12);
    #2;
    resetn = 1'b0;
    #1;
    check("async rst valid", 64'(out_valid), 64'd0);
    check("async rst busy", 64'(busy), 64'd0);
    check("async rst test_addr", 64'(test_addr), 64'd0);
    check("async rst out_data", 64'(out_data), 64'd0);
    check("async rst done", 64'(done), 64'd0);
    tick();
    tick();
    check("in rst done", 64'(done), 64'd0);
    resetn = 1'b1;
    tick();
    check("after rst done", 64'(done), 64'd0);
    check("after rst busy", 64'(busy), 64'd0);
    sweep(5'd12, 5'd14, 3, "post-rst");

`ifdef SCAN_ABORT_EN
    // Abort coinciding with the handshake at address 3
    start = 1'b1; first_addr = 5'd0; last_addr = 5'd31; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("abort pre addr %0d", k), 64'(out_addr), 64'(k));
      check($sformatf("abort pre valid %0d", k), 64'(out_valid), 64'd1);
      tick();
    end
    tick();
    check("abort at3 valid", 64'(out_valid), 64'd1);
    check("abort at3 addr", 64'(out_addr), 64'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort valid", 64'(out_valid), 64'd0);
    check("abort done", 64'(done), 64'd1);
    tick();
    check("abort done cleared", 64'(done), 64'd0);
    check("abort busy cleared", 64'(busy), 64'd0);
    tick();
    check("abort idle valid", 64'(out_valid), 64'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort in idle ignored", 64'(done), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
